// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared types and constants for the LED pattern sequencer.
//   mode_t  : debounced switch pair as a display mode.
//   state_t : pattern engine state.
//   PAT_*   : LED patterns loaded when a state is entered.
//   Helpers : mode-to-state mapping and per-state entry pattern.
// -----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_ON    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ON,
    ST_BLINK,
    ST_CHASE
  } state_t;

  localparam logic [3:0] PAT_ALL    = 4'b1111;
  localparam logic [3:0] PAT_NONE   = 4'b0000;
  localparam logic [3:0] PAT_CHASE0 = 4'b0001;

  function automatic state_t mode_to_state(input mode_t m);
    state_t s;
    unique case (m)
      MODE_OFF:   s = ST_OFF;
      MODE_BLINK: s = ST_BLINK;
      MODE_CHASE: s = ST_CHASE;
      default:    s = ST_ON;
    endcase
    return s;
  endfunction

  // BLINK starts lit so the first toggle turns the LEDs off.
  function automatic logic [3:0] entry_pattern(input state_t s);
    logic [3:0] p;
    unique case (s)
      ST_OFF:   p = PAT_NONE;
      ST_CHASE: p = PAT_CHASE0;
      default:  p = PAT_ALL;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
//   Two-flop synchroniser followed by a stability counter. The output only
//   follows the synchronised input after it has differed from the current
//   output for DB_CYCLES consecutive clocks.
//   Ports:
//     clk  in  system clock, rising edge
//     rst  in  synchronous active-high reset
//     din  in  raw asynchronous input
//     dout out debounced, registered output
// -----------------------------------------------------------------------------
module debounce
  import led_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synced value has disagreed with the
  // accepted value; any agreement restarts the run from zero. Comparing
  // against DB_CYCLES-1 makes the update land on the DB_CYCLES-th
  // disagreeing cycle.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    dout_d  = dout_q;
    cnt_d   = '0;
    if (sync2_q != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//   Debounces the two slide switches, uses them as a display mode and drives
//   four LEDs from a ticked pattern engine (off, on, blink, chase).
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   synchronous active-high reset
//     sw    in   [1:0] raw slide switches
//     led   out  [3:0] registered LED drive
//     mode  out  [1:0] current debounced mode
// -----------------------------------------------------------------------------
module led_sequencer
  import led_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 4,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic [3:0] led,
  output logic [1:0] mode
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [1:0]    db_sw;
  mode_t         cur_mode;
  state_t        target;
  logic          tick;

  state_t        state_q, state_d;
  logic [3:0]    led_q, led_d;
  logic [PW-1:0] presc_q, presc_d;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db0 (
    .clk  (clk),
    .rst  (rst),
    .din  (sw[0]),
    .dout (db_sw[0])
  );

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
    .clk  (clk),
    .rst  (rst),
    .din  (sw[1]),
    .dout (db_sw[1])
  );

  assign cur_mode = mode_t'(db_sw);
  assign target   = mode_to_state(cur_mode);
  assign tick     = (presc_q == PRESC_LAST);

  // A mode change is seen as the debounced mode disagreeing with the current
  // state. It takes priority over a coincident tick: the pattern reloads and
  // the prescaler restarts, so the first step is a full TICK_DIV later.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    if (target != state_q) begin
      state_d = target;
      led_d   = entry_pattern(target);
      presc_d = '0;
    end else if (tick) begin
      unique case (state_q)
        ST_BLINK: led_d = ~led_q;
        ST_CHASE: led_d = {led_q[2:0], led_q[3]};
        default:  led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      led_q   <= PAT_NONE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      presc_q <= presc_d;
    end
  end

  assign led  = led_q;
  assign mode = db_sw;

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//   Self-checking bench for led_sequencer with CLK_HZ=16, TICK_HZ=4,
//   DB_CYCLES=3. A reference model predicts mode and LEDs every cycle:
//   inputs reach the debouncer two edges late, a bit is accepted once the last
//   DB samples all disagree with it, and the LED value is a function of the
//   active mode and the number of edges since that mode was entered.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

  localparam int DB   = 3;
  localparam int TDIV = 4;

  typedef logic win_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic [3:0] led;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  logic [1:0] m_d1, m_d2;
  win_t       m_win0, m_win1;
  logic [1:0] m_deb;
  logic [1:0] m_state;
  int         m_age;
  logic [3:0] m_led;

  led_sequencer #(
    .CLK_HZ    (16),
    .TICK_HZ   (4),
    .DB_CYCLES (DB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .led  (led),
    .mode (mode)
  );

  always #5 clk = ~clk;

  // LED value expected age edges after entering mode md.
  function automatic logic [3:0] patternFor(input logic [1:0] md, input int age);
    int k;
    logic [3:0] one;
    logic [3:0] p;
    k   = age / TDIV;
    one = 4'b0001;
    case (md)
      2'b00:   p = 4'b0000;
      2'b11:   p = 4'b1111;
      2'b01:   p = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      default: p = one << (k % 4);
    endcase
    return p;
  endfunction

  function automatic logic allDiffer(input win_t q, input logic v);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == v) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one rising edge with the inputs held at that edge.
  task modelEdge(input logic r, input logic [1:0] s);
    logic [1:0] used;
    if (r) begin
      m_d1 = 2'b00;
      m_d2 = 2'b00;
      m_win0.delete();
      m_win1.delete();
      m_deb   = 2'b00;
      m_state = 2'b00;
      m_age   = 0;
      m_led   = 4'b0000;
    end else begin
      if (m_deb != m_state) begin
        m_state = m_deb;
        m_age   = 0;
      end else begin
        m_age++;
      end
      m_led = patternFor(m_state, m_age);
      used = m_d2;
      m_d2 = m_d1;
      m_d1 = s;
      m_win0.push_back(used[0]);
      m_win1.push_back(used[1]);
      if (m_win0.size() > DB) void'(m_win0.pop_front());
      if (m_win1.size() > DB) void'(m_win1.pop_front());
      if (allDiffer(m_win0, m_deb[0])) m_deb[0] = ~m_deb[0];
      if (allDiffer(m_win1, m_deb[1])) m_deb[1] = ~m_deb[1];
    end
  endtask

  task checkOutput(input string tag, input logic [3:0] expLed, input logic [1:0] expMode);
    checks++;
    assert (led === expLed) else begin
      errors++;
      $error("[TB] FAIL %s led=%b expected %b", tag, led, expLed);
    end
    checks++;
    assert (mode === expMode) else begin
      errors++;
      $error("[TB] FAIL %s mode=%b expected %b", tag, mode, expMode);
    end
  endtask

  // Drive inputs for n edges, checking the DUT against the model after each.
  task applyStimulus(input logic r, input logic [1:0] s, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rst = r;
      sw  = s;
      @(posedge clk);
      modelEdge(r, s);
      #1;
      checkOutput(tag, m_led, m_deb);
    end
  endtask

  initial begin
    logic [3:0] chaseSeq [4];
    logic [1:0] rs;
    int         rn;
    logic       rr;

    chaseSeq[0] = 4'b0010;
    chaseSeq[1] = 4'b0100;
    chaseSeq[2] = 4'b1000;
    chaseSeq[3] = 4'b0001;

    rst = 1'b1;
    sw  = 2'b11;
    m_d1 = 2'b00; m_d2 = 2'b00; m_deb = 2'b00; m_state = 2'b00;
    m_age = 0; m_led = 4'b0000;

    // 1: reset with switches on, then release
    applyStimulus(1'b1, 2'b11, 5, "reset");
    checkOutput("reset_state", 4'b0000, 2'b00);
    applyStimulus(1'b0, 2'b11, 5, "release_wait");
    checkOutput("release_5_edges", 4'b0000, 2'b11);
    applyStimulus(1'b0, 2'b11, 1, "release_on");
    checkOutput("release_6_edges", 4'b1111, 2'b11);

    // 2: short glitch from OFF is rejected
    applyStimulus(1'b0, 2'b00, 8, "to_off");
    checkOutput("off_state", 4'b0000, 2'b00);
    applyStimulus(1'b0, 2'b01, 2, "glitch");
    applyStimulus(1'b0, 2'b00, 8, "glitch_after");
    checkOutput("glitch_rejected", 4'b0000, 2'b00);

    // 3: chase with wrap
    applyStimulus(1'b0, 2'b10, 6, "chase_enter");
    checkOutput("chase_entry", 4'b0001, 2'b10);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b10, 4, "chase_step");
      checkOutput("chase_seq", chaseSeq[i], 2'b10);
    end

    // 4: blink
    applyStimulus(1'b0, 2'b01, 6, "blink_enter");
    checkOutput("blink_entry", 4'b1111, 2'b01);
    applyStimulus(1'b0, 2'b01, 4, "blink_step");
    checkOutput("blink_off", 4'b0000, 2'b01);
    applyStimulus(1'b0, 2'b01, 4, "blink_step");
    checkOutput("blink_on", 4'b1111, 2'b01);

    // 5: mode change landing on the tick edge
    applyStimulus(1'b0, 2'b10, 6, "chase_reenter");
    checkOutput("chase_reentry", 4'b0001, 2'b10);
    for (int i = 0; i < 4 && (m_age % TDIV) != 2; i++)
      applyStimulus(1'b0, 2'b10, 1, "align");
    applyStimulus(1'b0, 2'b01, 5, "tick_collide_wait");
    applyStimulus(1'b0, 2'b01, 1, "tick_collide");
    checkOutput("collide_reload", 4'b1111, 2'b01);
    applyStimulus(1'b0, 2'b01, 3, "collide_hold");
    checkOutput("collide_no_toggle", 4'b1111, 2'b01);
    applyStimulus(1'b0, 2'b01, 1, "collide_toggle");
    checkOutput("collide_first_toggle", 4'b0000, 2'b01);

    // 6: reset mid-chase
    applyStimulus(1'b0, 2'b10, 6, "chase_third");
    for (int i = 0; i < 16 && m_led != 4'b0100; i++)
      applyStimulus(1'b0, 2'b10, 1, "seek_0100");
    checkOutput("pre_reset_0100", 4'b0100, 2'b10);
    applyStimulus(1'b1, 2'b10, 1, "mid_reset");
    checkOutput("mid_reset_state", 4'b0000, 2'b00);
    applyStimulus(1'b0, 2'b10, 5, "resume_wait");
    checkOutput("resume_not_yet", 4'b0000, 2'b10);
    applyStimulus(1'b0, 2'b10, 1, "resume");
    checkOutput("resume_chase", 4'b0001, 2'b10);

    // Random switch activity with occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      rs = 2'($urandom_range(0, 3));
      rn = $urandom_range(1, 10);
      rr = ($urandom_range(0, 29) == 0);
      applyStimulus(rr, rs, rr ? 1 : rn, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
